// File: rtl/npu_ahb_row_master.sv
// npu_ahb_row_master
// Collects a pixel byte stream into 32-bit words and writes each word to
// the NPU input memory window with single AHB-Lite NONSEQ transfers.
// After every ROW_BYTES bytes it writes 1 to the write_row control register.
// After NUM_ROWS rows, or on a bus error response, it pulses done.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start                frame start pulse (only honoured in IDLE)
//   pix_valid/ready/data byte stream input (valid/ready handshake)
//   ahb_m0_*             AHB-Lite master (address/control/write data out,
//                        hready/hresp in)
//   busy                 frame in progress
//   done                 one-cycle end-of-frame pulse (also on error)
//   err                  sticky bus error, cleared by the next start
//   rows_sent            rows completed in the current frame
module npu_ahb_row_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] MEM_OFFSET  = 32'h0000_0000,
  parameter logic [31:0] CTRL_OFFSET = 32'h0000_1000,
  parameter int unsigned ROW_BYTES   = 84,
  parameter int unsigned NUM_ROWS    = 28
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [31:0] ahb_m0_haddr_o,
  output logic        ahb_m0_hwrite_o,
  output logic [2:0]  ahb_m0_hsize_o,
  output logic [2:0]  ahb_m0_hburst_o,
  output logic [3:0]  ahb_m0_hprot_o,
  output logic [1:0]  ahb_m0_htrans_o,
  output logic        ahb_m0_hmastlock_o,
  output logic [31:0] ahb_m0_hwdata_o,
  input  logic        ahb_m0_hready_i,
  input  logic        ahb_m0_hresp_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rows_sent
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, ADDR, DATA, CMD_ADDR, CMD_DATA, DONE
  } state_e;

  localparam logic [11:0] ROW_BYTES_W = 12'(ROW_BYTES);
  localparam logic [4:0]  NUM_ROWS_W  = 5'(NUM_ROWS);
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  state_e      state_q, state_d;
  logic [11:0] byte_addr_q, byte_addr_d;
  logic [4:0]  rows_sent_q, rows_sent_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  pack_cnt_q, pack_cnt_d;
  logic [11:0] byte_addr_inc;
  logic [4:0]  rows_inc;

  assign byte_addr_inc = byte_addr_q + 12'd4;
  assign rows_inc      = rows_sent_q + 5'd1;

  assign ahb_m0_hwrite_o    = 1'b1;
  assign ahb_m0_hsize_o     = 3'b010;
  assign ahb_m0_hburst_o    = 3'b000;
  assign ahb_m0_hprot_o     = 4'b0011;
  assign ahb_m0_hmastlock_o = 1'b0;
  assign err                = err_q;
  assign rows_sent          = rows_sent_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      byte_addr_q <= '0;
      rows_sent_q <= '0;
      err_q       <= 1'b0;
      word_q      <= '0;
      pack_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_addr_q <= byte_addr_d;
      rows_sent_q <= rows_sent_d;
      err_q       <= err_d;
      word_q      <= word_d;
      pack_cnt_q  <= pack_cnt_d;
    end
  end

  // Bus outputs are decoded from the state alone, so they are held stable
  // for as long as the FSM waits on hready.
  always_comb begin
    state_d         = state_q;
    byte_addr_d     = byte_addr_q;
    rows_sent_d     = rows_sent_q;
    err_d           = err_q;
    word_d          = word_q;
    pack_cnt_d      = pack_cnt_q;
    pix_ready       = 1'b0;
    ahb_m0_htrans_o = HTRANS_IDLE;
    ahb_m0_haddr_o  = '0;
    ahb_m0_hwdata_o = '0;
    busy            = 1'b1;
    done            = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d     = COLLECT;
          byte_addr_d = '0;
          rows_sent_d = '0;
          err_d       = 1'b0;
          pack_cnt_d  = '0;
        end
      end
      COLLECT: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          word_d[{pack_cnt_q, 3'b000} +: 8] = pix_data;
          pack_cnt_d = pack_cnt_q + 2'd1;
          if (pack_cnt_q == 2'd3) state_d = ADDR;
        end
      end
      ADDR: begin
        ahb_m0_htrans_o = HTRANS_NONSEQ;
        ahb_m0_haddr_o  = BASE_ADDR + MEM_OFFSET + {20'd0, byte_addr_q};
        if (ahb_m0_hready_i) state_d = DATA;
      end
      DATA: begin
        ahb_m0_hwdata_o = word_q;
        if (ahb_m0_hready_i) begin
          if (ahb_m0_hresp_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            byte_addr_d = byte_addr_inc;
            // byte_addr never wraps within a frame, so the row boundary is
            // simply the incremented address being a multiple of ROW_BYTES.
            state_d = ((byte_addr_inc % ROW_BYTES_W) == 12'd0) ? CMD_ADDR : COLLECT;
          end
        end
      end
      CMD_ADDR: begin
        ahb_m0_htrans_o = HTRANS_NONSEQ;
        ahb_m0_haddr_o  = BASE_ADDR + CTRL_OFFSET;
        if (ahb_m0_hready_i) state_d = CMD_DATA;
      end
      CMD_DATA: begin
        ahb_m0_hwdata_o = 32'h0000_0001;
        if (ahb_m0_hready_i) begin
          if (ahb_m0_hresp_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rows_sent_d = rows_inc;
            state_d     = (rows_inc == NUM_ROWS_W) ? DONE : COLLECT;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
